md_unit: RTL
============

Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage of the pipelined MIPS core.
- Consumes the EX operand pair. Operand B is either the forwarded rt value or the 32-bit immediate from the ID-stage sign/zero extender.
- Holds the architectural HI/LO registers and raises busy so the hazard unit can stall the next mult/div/mfhi/mflo/mthi/mtlo in ID.

Parameters:
MULT_CYCLES, 5, busy duration for mult/multu; legal range 1..15
DIV_CYCLES, 10, busy duration for div/divu; legal range 1..15

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous active-high reset
start  input  1  launch operation selected by op
op  input  2  0=mult, 1=multu, 2=div, 3=divu
a  input  32  operand A (rs)
b  input  32  operand B (rt or extended immediate)
hi_we  input  1  mthi: write a into HI
lo_we  input  1  mtlo: write a into LO
busy  output  1  operation in flight
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Clock/reset: one clock (clk). Reset is synchronous and active-high (reset). On a reset edge: hi=0, lo=0, busy=0, cycle counter=0, latched operands/op=0. Reset mid-operation aborts it; no HI/LO update occurs.
- States: IDLE (counter=0, busy=0) and RUN (counter>0, busy=1). busy is a registered output driven only by counter!=0.
- IDLE -> RUN on an edge with start=1 and busy=0:
  - Latch a, b, op.
  - Counter loads MULT_CYCLES when op[1]=0, DIV_CYCLES when op[1]=1.
  - busy goes high the following cycle.
- RUN: each edge decrements the counter. On the edge where counter==1:
  - HI/LO are written with the result.
  - Counter goes to 0 and busy drops.
  - busy is high for exactly N cycles; new HI/LO are visible in the cycle busy first reads 0.
- start while busy=1 is ignored. The hazard unit must stall, so this is a protocol violation; the unit must not corrupt the in-flight operation.
- hi_we/lo_we:
  - When busy=0 and start=0: the write takes effect on that edge. hi_we and lo_we may both be high; both registers then take a.
  - Ignored while busy=1, and ignored in a cycle with an accepted start (start wins).
- Arithmetic, on latched operands:
  - mult: signed 32x32 -> 64-bit product. HI=product[63:32], LO=product[31:0].
  - multu: same, unsigned.
  - div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - Overflow case 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (b==0, div or divu): still busy for DIV_CYCLES; HI and LO retain their prior values.
- hi/lo outputs are direct register values. There is no bypass of an in-progress result or of a same-cycle hi_we/lo_we.
- Computation may be a single combinational operator sampled at completion, or iterative. Only the cycle timing above is architectural.

Test Plan:
- Reset, then mult with a=0xFFFFFFFF, b=0x00000002 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles. Follow with div a=0xFFFFFFF9 (-7), b=2 -> 10 busy cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu a=7, b=2 -> lo=3, hi=1. Then div with b=0 -> busy 10 cycles; hi=1, lo=3 unchanged. Then div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- During a divu (a=100, b=7), pulse start with op=mult, a=b=5, and pulse hi_we=1 with a=0xDEAD -> both ignored; final lo=14, hi=2, busy timing unchanged.
- Idle: hi_we=1 with a=0x12345678 and lo_we=1 in the same cycle -> hi=lo=0x12345678 next cycle. Then start and lo_we together -> start executes, lo_we dropped.
- Start mult a=3, b=4; assert reset on the 3rd busy cycle -> next cycle busy=0, hi=lo=0; no later update appears.

Source files
------------

// File: rtl/md_unit_if.sv
// Multiply/divide unit bus: launch controls, operands, mthi/mtlo writes, and HI/LO/busy status.
interface md_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    // Pipeline/bench side drives requests and observes status.
    modport master (
        output start, op, a, b, hi_we, lo_we,
        input  busy, hi, lo
    );

    // Unit side.
    modport slave (
        input  start, op, a, b, hi_we, lo_we,
        output busy, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle MIPS multiply/divide unit holding the architectural HI/LO registers.
// The result is computed combinationally from latched operands and written on the final
// busy cycle; the cycle counter alone sets the architectural timing.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic      clk,
    input logic      reset,
    md_unit_if.slave md
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        signed_op;
    logic        a_neg;
    logic        b_neg;
    logic [63:0] prod;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] den;
    logic [31:0] quot_mag;
    logic [31:0] rem_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        div_by_zero;

    // Result datapath on latched operands: sign-magnitude division so the
    // 0x80000000 / -1 case falls out naturally (quotient 0x80000000, remainder 0).
    always_comb begin
        signed_op   = ~op_q[0];
        a_neg       = signed_op & a_q[31];
        b_neg       = signed_op & b_q[31];
        prod        = {{32{a_neg}}, a_q} * {{32{b_neg}}, b_q};
        a_mag       = a_neg ? -a_q : a_q;
        b_mag       = b_neg ? -b_q : b_q;
        div_by_zero = (b_q == 32'd0);
        den         = div_by_zero ? 32'd1 : b_mag;
        quot_mag    = a_mag / den;
        rem_mag     = a_mag % den;
        quot        = (a_neg ^ b_neg) ? -quot_mag : quot_mag;
        rem         = a_neg ? -rem_mag : rem_mag;
        res_hi      = op_q[1] ? rem  : prod[63:32];
        res_lo      = op_q[1] ? quot : prod[31:0];
    end

    // Next-state: launch, countdown, completion write-back, and mthi/mtlo when idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            StIdle: begin
                if (md.start) begin
                    a_d     = md.a;
                    b_d     = md.b;
                    op_d    = md.op;
                    cnt_d   = md.op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                    state_d = StRun;
                end else begin
                    if (md.hi_we) hi_d = md.a;
                    if (md.lo_we) lo_d = md.a;
                end
            end
            StRun: begin
                // start/hi_we/lo_we are deliberately ignored here.
                if (cnt_q == 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = StIdle;
                    // Divide by zero leaves HI/LO untouched.
                    if (!(op_q[1] && div_by_zero)) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        endcase
    end

    // State registers with synchronous reset; reset aborts any in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 2'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign md.busy = (cnt_q != 4'd0);
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

endmodule
